legv8_fetch_unit: RTL and testbench

Instruction-fetch stage of the pipelined LEGv8 core. Owns the program counter, drives the address into the combinational instruction memory `IC`, and captures each returned 32-bit word with its PC into a 2-entry skid buffer that forms the IF/ID pipeline register. Fetch continues while decode is stalled until the buffer is full. A taken-branch redirect flushes the buffer and reloads the PC.

---
 rtl/legv8_pkg.sv | 18 +
 rtl/fetch_skid_buffer.sv | 84 ++++++++
 rtl/legv8_fetch_unit.sv | 72 +++++++
 tb/tb_legv8_fetch_unit.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/legv8_pkg.sv
// Shared types and constants for the LEGv8 fetch stage.
package legv8_pkg;

    localparam int ADDR_W  = 64;
    localparam int INSTR_W = 32;
    localparam logic [ADDR_W-1:0] PC_STEP = 64'd4;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Branch targets are word aligned by clearing the two low bits.
    function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] addr);
        return addr & ~64'd3;
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// Two-entry FIFO holding fetched {pc, instr} pairs; forms the IF/ID register.
module fetch_skid_buffer
    import legv8_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  fetch_entry_t push_entry_i,
    output logic         full_o,
    output logic         empty_o,
    output fetch_entry_t head_o
);

    fetch_entry_t entry_q [2];
    fetch_entry_t entry_d [2];
    logic         head_q;
    logic         head_d;
    logic [1:0]   count_q;
    logic [1:0]   count_d;
    logic         tail_s;
    logic         do_push_s;
    logic         do_pop_s;

    // Next-state for pointers, occupancy and the tail slot.
    always_comb begin
        do_push_s = push_i & ~flush_i;
        do_pop_s  = pop_i & ~flush_i & (count_q != 2'd0);
        // When full, the tail aliases the head slot, which a same-cycle pop frees.
        tail_s    = head_q ^ count_q[0];
        entry_d   = entry_q;
        if (do_push_s) begin
            entry_d[tail_s] = push_entry_i;
        end else begin
            entry_d[tail_s] = entry_q[tail_s];
        end

        if (flush_i) begin
            head_d = 1'b0;
        end else if (do_pop_s) begin
            head_d = ~head_q;
        end else begin
            head_d = head_q;
        end

        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        if (flush_i) begin
            count_d = 2'd0;
        end else begin
            count_d = count_d;
        end
    end

    // Buffer state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            entry_q[0] <= '0;
            entry_q[1] <= '0;
            head_q     <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            entry_q    <= entry_d;
            head_q     <= head_d;
            count_q    <= count_d;
        end
    end

    // Status and head view, zeroed while empty.
    always_comb begin
        full_o  = (count_q == 2'd2);
        empty_o = (count_q == 2'd0);
        if (empty_o) begin
            head_o = '0;
        end else begin
            head_o = entry_q[head_q];
        end
    end

endmodule

// File: rtl/legv8_fetch_unit.sv
// LEGv8 instruction fetch: PC register, redirect handling and IF/ID skid buffer.
module legv8_fetch_unit
    import legv8_pkg::*;
#(
    parameter logic [ADDR_W-1:0] PC_RESET = 64'h0
) (
    input  logic               CLOCK,
    input  logic               RESET,
    output logic [ADDR_W-1:0]  pc_out,
    input  logic [INSTR_W-1:0] ic_in,
    input  logic               stall,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               if_id_valid,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [ADDR_W-1:0]  if_id_pc
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic              pop_s;
    logic              push_s;
    logic              full_s;
    logic              empty_s;
    fetch_entry_t      push_entry_s;
    fetch_entry_t      head_s;

    // Fetch control; redirect overrides stall, push and pop.
    always_comb begin
        pop_s  = ~empty_s & ~stall & ~redirect;
        push_s = ~redirect & (~full_s | pop_s);
        push_entry_s.pc    = pc_q;
        push_entry_s.instr = ic_in;
        if (redirect) begin
            pc_d = align_pc(redirect_pc);
        end else if (push_s) begin
            pc_d = pc_q + PC_STEP;
        end else begin
            pc_d = pc_q;
        end
    end

    // Program counter register.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            pc_q <= PC_RESET;
        end else begin
            pc_q <= pc_d;
        end
    end

    fetch_skid_buffer u_buf (
        .clk_i        (CLOCK),
        .rst_i        (RESET),
        .push_i       (push_s),
        .pop_i        (pop_s),
        .flush_i      (redirect),
        .push_entry_i (push_entry_s),
        .full_o       (full_s),
        .empty_o      (empty_s),
        .head_o       (head_s)
    );

    // Outputs are taken only from registered state.
    always_comb begin
        pc_out      = pc_q;
        if_id_valid = ~empty_s;
        if_id_instr = head_s.instr;
        if_id_pc    = head_s.pc;
    end

endmodule

// File: tb/tb_legv8_fetch_unit.sv
// Self-checking bench for legv8_fetch_unit: directed table, reset corner, random vs queue model.
module tb_legv8_fetch_unit;

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic [63:0] pc_out;
    logic [31:0] ic_in;
    logic        stall;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [63:0] if_id_pc;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLOCK = ~CLOCK;

    function automatic logic [31:0] ic_word(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h5A00_0000;
    endfunction

    // Instruction memory model: word is a fixed function of the address.
    assign ic_in = ic_word(pc_out);

    legv8_fetch_unit dut (
        .CLOCK       (CLOCK),
        .RESET       (RESET),
        .pc_out      (pc_out),
        .ic_in       (ic_in),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_id_valid (if_id_valid),
        .if_id_instr (if_id_instr),
        .if_id_pc    (if_id_pc)
    );

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [63:0] e_pc,
                             input logic e_valid, input logic [63:0] e_ifpc);
        cmp({tag, " pc_out"}, pc_out, e_pc);
        cmp({tag, " valid"}, {63'd0, if_id_valid}, {63'd0, e_valid});
        cmp({tag, " if_id_pc"}, if_id_pc, e_valid ? e_ifpc : 64'h0);
        cmp({tag, " if_id_instr"}, {32'd0, if_id_instr},
            e_valid ? {32'd0, ic_word(e_ifpc)} : 64'h0);
    endtask

    task automatic step(input logic s, input logic r, input logic [63:0] rp);
        stall       = s;
        redirect    = r;
        redirect_pc = rp;
        @(posedge CLOCK);
        #1;
    endtask

    typedef struct {
        logic        stall;
        logic        redir;
        logic [63:0] rpc;
        logic [63:0] exp_pc;
        logic        exp_valid;
        logic [63:0] exp_ifpc;
    } vec_t;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } mentry_t;

    vec_t        vecs [17];
    mentry_t     q [$];
    logic [63:0] m_pc;
    mentry_t     e;

    initial begin
        // Row i: inputs in cycle i, expected outputs in cycle i+1.
        vecs[0]  = '{1'b0, 1'b0, 64'h0,   64'h4,   1'b1, 64'h0};
        vecs[1]  = '{1'b1, 1'b0, 64'h0,   64'h8,   1'b1, 64'h0};
        vecs[2]  = '{1'b1, 1'b0, 64'h0,   64'h8,   1'b1, 64'h0};
        vecs[3]  = '{1'b1, 1'b0, 64'h0,   64'h8,   1'b1, 64'h0};
        vecs[4]  = '{1'b0, 1'b0, 64'h0,   64'hC,   1'b1, 64'h4};
        vecs[5]  = '{1'b0, 1'b0, 64'h0,   64'h10,  1'b1, 64'h8};
        vecs[6]  = '{1'b1, 1'b0, 64'h0,   64'h10,  1'b1, 64'h8};
        vecs[7]  = '{1'b1, 1'b1, 64'h100, 64'h100, 1'b0, 64'h0};
        vecs[8]  = '{1'b0, 1'b0, 64'h0,   64'h104, 1'b1, 64'h100};
        vecs[9]  = '{1'b0, 1'b1, 64'h203, 64'h200, 1'b0, 64'h0};
        vecs[10] = '{1'b0, 1'b1, 64'h40,  64'h40,  1'b0, 64'h0};
        vecs[11] = '{1'b0, 1'b1, 64'h80,  64'h80,  1'b0, 64'h0};
        vecs[12] = '{1'b0, 1'b0, 64'h0,   64'h84,  1'b1, 64'h80};
        vecs[13] = '{1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 64'h0};
        vecs[14] = '{1'b0, 1'b0, 64'h0,   64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8};
        vecs[15] = '{1'b0, 1'b0, 64'h0,   64'h0,   1'b1, 64'hFFFF_FFFF_FFFF_FFFC};
        vecs[16] = '{1'b0, 1'b0, 64'h0,   64'h4,   1'b1, 64'h0};

        RESET       = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 64'h0;
        #12;
        check_out("in_reset", 64'h0, 1'b0, 64'h0);
        @(negedge CLOCK);
        RESET = 1'b0;
        check_out("cycle0", 64'h0, 1'b0, 64'h0);

        for (int i = 0; i < 17; i++) begin
            step(vecs[i].stall, vecs[i].redir, vecs[i].rpc);
            check_out($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_valid, vecs[i].exp_ifpc);
        end

        // Fill the buffer under stall, then reset asynchronously mid-cycle.
        step(1'b1, 1'b0, 64'h0);
        step(1'b1, 1'b0, 64'h0);
        check_out("full_stall", 64'h8, 1'b1, 64'h0);
        #2;
        RESET = 1'b1;
        #1;
        check_out("async_reset", 64'h0, 1'b0, 64'h0);
        @(negedge CLOCK);
        RESET = 1'b0;
        stall = 1'b0;
        check_out("post_reset0", 64'h0, 1'b0, 64'h0);
        step(1'b0, 1'b0, 64'h0);
        check_out("post_reset1", 64'h4, 1'b1, 64'h0);
        step(1'b0, 1'b0, 64'h0);
        check_out("post_reset2", 64'h8, 1'b1, 64'h4);

        // Random phase against a queue model, from a fresh reset.
        #2;
        RESET = 1'b1;
        @(negedge CLOCK);
        RESET = 1'b0;
        m_pc = 64'h0;
        q.delete();
        for (int i = 0; i < 400; i++) begin
            logic        s;
            logic        r;
            logic [63:0] rp;
            s  = ($urandom_range(0, 9) < 4);
            r  = ($urandom_range(0, 11) == 0);
            rp = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) rp = 64'hFFFF_FFFF_FFFF_FFF0 | 64'(rp[3:0]);
            step(s, r, rp);
            if (r) begin
                q.delete();
                m_pc = {rp[63:2], 2'b00};
            end else begin
                if (q.size() > 0 && !s) begin
                    e = q.pop_front();
                end
                if (q.size() < 2) begin
                    e.pc    = m_pc;
                    e.instr = ic_word(m_pc);
                    q.push_back(e);
                    m_pc = m_pc + 64'd4;
                end
            end
            check_out($sformatf("rand%0d", i), m_pc, (q.size() > 0),
                      (q.size() > 0) ? q[0].pc : 64'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
